// File: rtl/geom_feeder_pkg.sv
// Shared types, packing helpers and defaults for the per-frame geometry feeder.
package geom_feeder_pkg;

    localparam int COORD_W    = 10;
    localparam int TRI_W      = 6 * COORD_W;
    localparam int VTX_STRIDE = 2 * COORD_W;
    localparam int X0_LSB     = 50;
    localparam int Y0_LSB     = 40;
    localparam int OFF_W      = 11;

    localparam int H_MAX_DEF = 639;
    localparam int V_MAX_DEF = 479;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [TRI_W-1:0]   tri_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XF0,
        ST_XF1,
        ST_XF2,
        ST_CULL,
        ST_COMMIT
    } state_t;

    // Vertex v occupies {x,y} starting at bit 59 - 20*v, x above y.
    function automatic coord_t get_x(input tri_t t, input logic [1:0] v);
        return coord_t'(t >> (X0_LSB - VTX_STRIDE * int'(v)));
    endfunction

    function automatic coord_t get_y(input tri_t t, input logic [1:0] v);
        return coord_t'(t >> (Y0_LSB - VTX_STRIDE * int'(v)));
    endfunction

    function automatic tri_t pack_tri(input coord_t x0, input coord_t y0,
                                      input coord_t x1, input coord_t y1,
                                      input coord_t x2, input coord_t y2);
        return {x0, y0, x1, y1, x2, y2};
    endfunction

endpackage

// File: rtl/geom_feeder_vtx_clamp.sv
// One coordinate: add a signed offset and clamp the result into [0, max_val].
module vtx_clamp
    import geom_feeder_pkg::*;
(
    input  logic [COORD_W-1:0] coord,
    input  logic [OFF_W-1:0]   off,
    input  logic [COORD_W-1:0] max_val,
    output logic [COORD_W-1:0] result
);

    logic [11:0] sum;

    // 12 bits covers 0..1023 plus -1024..+1023 without overflow.
    assign sum = {2'b00, coord} + {off[OFF_W-1], off};

    always_comb begin
        if (sum[11]) begin
            result = '0;
        end else if (sum[10:0] > {1'b0, max_val}) begin
            result = max_val;
        end else begin
            result = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/geom_feeder.sv
// Per-frame triangle fetch, offset/clamp transform and commit to the scan-converter.
// Optional back-face culling stage is enabled with `define GEOM_FEEDER_CULL_EN.
module geom_feeder
    import geom_feeder_pkg::*;
#(
    parameter int NUM_TRI = 4,
    parameter int H_MAX   = H_MAX_DEF,
    parameter int V_MAX   = V_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [TRI_W-1:0] wr_data,
    input  logic [OFF_W-1:0] off_x,
    input  logic [OFF_W-1:0] off_y,
    input  logic             seq_en,
    output logic [TRI_W-1:0] geometry,
    output logic             geom_valid,
    output logic [9:0]       frame_count,
    output logic [2:0]       cur_idx
);

    localparam int         IDX_W     = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;
    localparam logic [3:0] NUM_TRI_L = 4'(NUM_TRI);
    localparam logic [2:0] IDX_MASK  = 3'(NUM_TRI - 1);
    localparam coord_t     H_MAX_C   = coord_t'(H_MAX);
    localparam coord_t     V_MAX_C   = coord_t'(V_MAX);

    state_t             state_reg, state_next;
    logic               vsync_q;
    logic               frame_start;
    logic               wr_accept;
    logic               wr_in_range;
    tri_t               table_reg [NUM_TRI];
    tri_t               fetch_tri;
    tri_t               work_reg;
    logic [OFF_W-1:0]   off_x_reg, off_y_reg;
    coord_t             sx_reg [3];
    coord_t             sy_reg [3];
    logic [1:0]         vtx_sel;
    logic               xf_active;
    coord_t             vx_in, vy_in, vx_out, vy_out;
    logic               commit_keep;
    logic               wr_ready_reg;
    tri_t               geometry_reg;
    logic               geom_valid_reg;
    logic [9:0]         frame_count_reg;
    logic [2:0]         cur_idx_reg;

    assign wr_ready    = wr_ready_reg;
    assign geometry    = geometry_reg;
    assign geom_valid  = geom_valid_reg;
    assign frame_count = frame_count_reg;
    assign cur_idx     = cur_idx_reg;

    assign frame_start = vsync & ~vsync_q & (state_reg == ST_IDLE);
    assign wr_accept   = wr_valid & wr_ready_reg;
    assign wr_in_range = {1'b0, wr_addr} < NUM_TRI_L;

    // A write landing in the frame_start cycle on the fetched slot is forwarded.
    assign fetch_tri = (wr_accept && wr_in_range && (wr_addr == cur_idx_reg))
                     ? wr_data : table_reg[cur_idx_reg[IDX_W-1:0]];

    generate
        for (genvar gi = 0; gi < NUM_TRI; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    table_reg[gi] <= '0;
                end else if (wr_accept && wr_in_range &&
                             (wr_addr[IDX_W-1:0] == IDX_W'(gi))) begin
                    table_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vtx_sel    = 2'd0;
        xf_active  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_XF0;
                end
            end
            ST_XF0: begin
                vtx_sel    = 2'd0;
                xf_active  = 1'b1;
                state_next = ST_XF1;
            end
            ST_XF1: begin
                vtx_sel    = 2'd1;
                xf_active  = 1'b1;
                state_next = ST_XF2;
            end
            ST_XF2: begin
                vtx_sel    = 2'd2;
                xf_active  = 1'b1;
`ifdef GEOM_FEEDER_CULL_EN
                state_next = ST_CULL;
`else
                state_next = ST_COMMIT;
`endif
            end
`ifdef GEOM_FEEDER_CULL_EN
            ST_CULL:   state_next = ST_COMMIT;
`endif
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign vx_in = get_x(work_reg, vtx_sel);
    assign vy_in = get_y(work_reg, vtx_sel);

    vtx_clamp u_clamp_x (
        .coord   (vx_in),
        .off     (off_x_reg),
        .max_val (H_MAX_C),
        .result  (vx_out)
    );

    vtx_clamp u_clamp_y (
        .coord   (vy_in),
        .off     (off_y_reg),
        .max_val (V_MAX_C),
        .result  (vy_out)
    );

`ifdef GEOM_FEEDER_CULL_EN
    logic signed [10:0] dx1, dy2, dx2, dy1;
    logic signed [21:0] prod_a, prod_b;
    logic signed [22:0] area;
    logic               cull_reg;

    assign dx1    = $signed({1'b0, sx_reg[1]}) - $signed({1'b0, sx_reg[0]});
    assign dy2    = $signed({1'b0, sy_reg[2]}) - $signed({1'b0, sy_reg[0]});
    assign dx2    = $signed({1'b0, sx_reg[2]}) - $signed({1'b0, sx_reg[0]});
    assign dy1    = $signed({1'b0, sy_reg[1]}) - $signed({1'b0, sy_reg[0]});
    assign prod_a = dx1 * dy2;
    assign prod_b = dx2 * dy1;
    assign area   = {prod_a[21], prod_a} - {prod_b[21], prod_b};

    // Zero or negative winding means degenerate or back-facing: drop it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cull_reg <= 1'b0;
        end else if (state_reg == ST_CULL) begin
            cull_reg <= (area <= 23'sd0);
        end
    end

    assign commit_keep = ~cull_reg;
`else
    assign commit_keep = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q         <= 1'b0;
            wr_ready_reg    <= 1'b0;
            off_x_reg       <= '0;
            off_y_reg       <= '0;
            work_reg        <= '0;
            for (int i = 0; i < 3; i++) begin
                sx_reg[i] <= '0;
                sy_reg[i] <= '0;
            end
            geometry_reg    <= '0;
            geom_valid_reg  <= 1'b0;
            frame_count_reg <= '0;
            cur_idx_reg     <= '0;
        end else begin
            vsync_q      <= vsync;
            wr_ready_reg <= (state_next == ST_IDLE);
            if (frame_start) begin
                off_x_reg <= off_x;
                off_y_reg <= off_y;
                work_reg  <= fetch_tri;
            end
            if (xf_active) begin
                sx_reg[vtx_sel] <= vx_out;
                sy_reg[vtx_sel] <= vy_out;
            end
            if (state_reg == ST_COMMIT) begin
                if (commit_keep) begin
                    geometry_reg   <= pack_tri(sx_reg[0], sy_reg[0], sx_reg[1],
                                               sy_reg[1], sx_reg[2], sy_reg[2]);
                    geom_valid_reg <= 1'b1;
                end else begin
                    geometry_reg   <= '0;
                    geom_valid_reg <= 1'b0;
                end
                frame_count_reg <= frame_count_reg + 10'd1;
                if (seq_en) begin
                    cur_idx_reg <= (cur_idx_reg + 3'd1) & IDX_MASK;
                end
            end
        end
    end

endmodule
